cfeb_kchar_gen: RTL and testbench

CFEB_KCHAR_GEN -- requirements
Module: cfeb_kchar_gen

---
 rtl/cfeb_kchar_gen_pkg.sv | 20 ++
 rtl/cfeb_kchar_inject.sv | 48 ++++
 rtl/cfeb_kchar_gen.sv | 126 ++++++++++++
 tb/tb_cfeb_kchar_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cfeb_kchar_gen_pkg.sv
// Shared CFEB link definitions: K-character codes and the transmitter FSM
// state encoding. The link sync monitor uses the same constants.
package cfeb_kchar_gen_pkg;

  // K28.5: normal frame separator
  localparam logic [7:0] K28_5_IDLE = 8'hBC;
  // K28.7: periodic marker sent once per marker cycle
  localparam logic [7:0] K28_7_FC   = 8'hFC;

  // Transmitter state encoding
  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_RESYNC = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Increment with wrap to zero after the given last value
  function automatic logic [7:0] wrap_inc(input logic [7:0] cnt, input logic [7:0] last);
    return (cnt == last) ? 8'd0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/cfeb_kchar_inject.sv
// Injection slot holder: keeps one pending substitute K-character and
// releases it on the first outgoing frame that is not an FC marker slot.
module cfeb_kchar_inject
  import cfeb_kchar_gen_pkg::*;
(
  input  logic       clock,
  input  logic       global_reset,
  input  logic       run_stay,      // RUN this cycle and RUN again next cycle
  input  logic       inj_req,
  input  logic [7:0] inj_kchar,
  input  logic       fc_slot_next,  // next frame is the FC marker slot
  output logic       emit,          // next frame carries the substitute
  output logic [7:0] emit_kchar
);

  logic       pending_reg;
  logic       pending_next;
  logic [7:0] captured_reg;
  logic [7:0] captured_next;
  logic       take;

  // A new request is accepted only in RUN and only when nothing is waiting;
  // a request arriving in the same cycle can be emitted straight away.
  always_comb begin
    take          = run_stay & inj_req & ~pending_reg;
    emit          = run_stay & (pending_reg | take) & ~fc_slot_next;
    emit_kchar    = pending_reg ? captured_reg : inj_kchar;
    captured_next = take ? inj_kchar : captured_reg;
    // Leaving RUN drops whatever is waiting, without an acknowledge
    if (!run_stay) begin
      pending_next = 1'b0;
    end else begin
      pending_next = (pending_reg | take) & ~emit;
    end
  end

  // Pending flag and captured character
  always_ff @(posedge clock) begin
    if (global_reset) begin
      pending_reg  <= 1'b0;
      captured_reg <= 8'd0;
    end else begin
      pending_reg  <= pending_next;
      captured_reg <= captured_next;
    end
  end

endmodule

// File: rtl/cfeb_kchar_gen.sv
// CFEB frame-separator generator: OFF / RESYNC / RUN sequencer producing the
// per-frame K-character, the marker-cycle position and sync status.
module cfeb_kchar_gen
  import cfeb_kchar_gen_pkg::*;
#(
  parameter int         FC_PERIOD   = 256,
  parameter int         RESYNC_HOLD = 16,
  parameter logic [7:0] IDLE_K      = K28_5_IDLE,
  parameter logic [7:0] FC_K        = K28_7_FC
) (
  input  logic       clock,
  input  logic       global_reset,
  input  logic       ttc_resync,
  input  logic       fiber_enable,
  input  logic       inj_req,
  input  logic [7:0] inj_kchar,
  output logic [7:0] kchar,
  output logic       tx_active,
  output logic       sync_done,
  output logic [7:0] frame_cnt,
  output logic       inj_ack
);

  localparam logic [7:0] FC_LAST   = 8'(FC_PERIOD - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RESYNC_HOLD - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] kchar_reg, kchar_next;
  logic       inj_ack_reg, inj_ack_next;

  logic [7:0] frame_inc;
  logic       fc_slot_next;
  logic       run_stay;
  logic       emit;
  logic [7:0] emit_kchar;

  // Frame position the next RUN cycle would carry, and whether it is the FC slot
  always_comb begin
    frame_inc    = wrap_inc(frame_cnt_reg, FC_LAST);
    fc_slot_next = (frame_inc == FC_LAST);
    run_stay     = (state_reg == ST_RUN) & fiber_enable & ~ttc_resync;
  end

  cfeb_kchar_inject u_inject (
    .clock        (clock),
    .global_reset (global_reset),
    .run_stay     (run_stay),
    .inj_req      (inj_req),
    .inj_kchar    (inj_kchar),
    .fc_slot_next (fc_slot_next),
    .emit         (emit),
    .emit_kchar   (emit_kchar)
  );

  // Next state and next registered outputs; disable outranks resync
  always_comb begin
    state_next     = ST_OFF;
    hold_cnt_next  = 8'd0;
    frame_cnt_next = 8'd0;
    kchar_next     = 8'd0;
    inj_ack_next   = 1'b0;
    if (fiber_enable) begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_RESYNC;
          kchar_next = IDLE_K;
        end
        ST_RESYNC: begin
          kchar_next = IDLE_K;
          if (ttc_resync) begin
            state_next = ST_RESYNC;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_next = ST_RUN;
          end else begin
            state_next    = ST_RESYNC;
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
        ST_RUN: begin
          if (ttc_resync) begin
            state_next = ST_RESYNC;
            kchar_next = IDLE_K;
          end else begin
            state_next     = ST_RUN;
            frame_cnt_next = frame_inc;
            if (fc_slot_next) begin
              kchar_next = FC_K;
            end else if (emit) begin
              kchar_next   = emit_kchar;
              inj_ack_next = 1'b1;
            end else begin
              kchar_next = IDLE_K;
            end
          end
        end
        default: state_next = ST_OFF;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_reg     <= ST_OFF;
      hold_cnt_reg  <= 8'd0;
      frame_cnt_reg <= 8'd0;
      kchar_reg     <= 8'd0;
      inj_ack_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      kchar_reg     <= kchar_next;
      inj_ack_reg   <= inj_ack_next;
    end
  end

  assign kchar     = kchar_reg;
  assign frame_cnt = frame_cnt_reg;
  assign inj_ack   = inj_ack_reg;
  assign tx_active = (state_reg == ST_RESYNC) | (state_reg == ST_RUN);
  assign sync_done = (state_reg == ST_RUN);

endmodule

// File: tb/tb_cfeb_kchar_gen.sv
// Bench for cfeb_kchar_gen: directed startup/marker/resync/injection/disable
// sequence followed by a randomized run, all checked against a cycle model.
module tb_cfeb_kchar_gen;

  localparam int P    = 256;
  localparam int HOLD = 16;

  logic       clock = 1'b0;
  logic       global_reset = 1'b1;
  logic       ttc_resync = 1'b0;
  logic       fiber_enable = 1'b0;
  logic       inj_req = 1'b0;
  logic [7:0] inj_kchar = 8'h00;
  logic [7:0] kchar;
  logic       tx_active;
  logic       sync_done;
  logic [7:0] frame_cnt;
  logic       inj_ack;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=off, 1=resync, 2=run
  int         m_mode = 0;
  int         m_resync_cycles = 0;
  int         m_frame = 0;
  logic [7:0] m_kchar = 8'h00;
  bit         m_ack = 1'b0;
  logic [7:0] m_wait_q[$];

  cfeb_kchar_gen dut (
    .clock        (clock),
    .global_reset (global_reset),
    .ttc_resync   (ttc_resync),
    .fiber_enable (fiber_enable),
    .inj_req      (inj_req),
    .inj_kchar    (inj_kchar),
    .kchar        (kchar),
    .tx_active    (tx_active),
    .sync_done    (sync_done),
    .frame_cnt    (frame_cnt),
    .inj_ack      (inj_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sampled
  task automatic model_update();
    m_ack = 1'b0;
    if (global_reset || !fiber_enable) begin
      m_mode = 0; m_frame = 0; m_kchar = 8'h00; m_resync_cycles = 0;
      m_wait_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1; m_resync_cycles = 1; m_kchar = 8'hBC;
    end else if (m_mode == 1) begin
      m_kchar = 8'hBC;
      if (ttc_resync) m_resync_cycles = 1;
      else if (m_resync_cycles == HOLD) begin m_mode = 2; m_frame = 0; end
      else m_resync_cycles++;
    end else begin
      if (ttc_resync) begin
        m_mode = 1; m_resync_cycles = 1; m_kchar = 8'hBC; m_frame = 0;
        m_wait_q.delete();
      end else begin
        m_frame = (m_frame + 1) % P;
        if (inj_req && m_wait_q.size() == 0) m_wait_q.push_back(inj_kchar);
        if (m_frame == P - 1) m_kchar = 8'hFC;
        else if (m_wait_q.size() != 0) begin
          m_kchar = m_wait_q.pop_front();
          m_ack = 1'b1;
        end else m_kchar = 8'hBC;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    chk("kchar", 32'(kchar), 32'(m_kchar));
    chk("frame_cnt", 32'(frame_cnt), (m_mode == 2) ? m_frame : 0);
    chk("tx_active", 32'(tx_active), 32'(m_mode != 0));
    chk("sync_done", 32'(sync_done), 32'(m_mode == 2));
    chk("inj_ack", 32'(inj_ack), 32'(m_ack));
  endtask

  task automatic run_until_frame(input int target);
    int n;
    n = 0;
    while (frame_cnt != 8'(target) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) chk("wait_frame", 32'(frame_cnt), target);
  endtask

  initial begin
    int fc_seen;
    int lvl;
    // Reset with enable raised during reset
    step(); step();
    fiber_enable = 1'b1;
    step();
    chk("rst_kchar", 32'(kchar), 0);
    chk("rst_tx", 32'(tx_active), 0);
    chk("rst_frame", 32'(frame_cnt), 0);
    global_reset = 1'b0;

    // Startup: 16 idle resync cycles then RUN at frame 0
    for (int i = 0; i < HOLD; i++) begin
      step();
      chk("start_bc", 32'(kchar), 32'h0BC);
      chk("start_tx", 32'(tx_active), 1);
      chk("start_sync", 32'(sync_done), 0);
    end
    step();
    chk("start_sync17", 32'(sync_done), 1);
    chk("start_frame17", 32'(frame_cnt), 0);

    // Marker period over 1100 cycles
    fc_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (kchar == 8'hFC) begin
        fc_seen++;
        chk("fc_pos", 32'(frame_cnt), 255);
      end
    end
    chk("fc_count", fc_seen, 4);

    // Resync at frame 100
    run_until_frame(100);
    ttc_resync = 1'b1;
    step();
    ttc_resync = 1'b0;
    chk("rs_sync0", 32'(sync_done), 0);
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk("rs_bc", 32'(kchar), 32'h0BC);
    end
    step();
    chk("rs_run", 32'(sync_done), 1);
    chk("rs_frame0", 32'(frame_cnt), 0);

    // Injection at frame 10
    run_until_frame(10);
    inj_req = 1'b1; inj_kchar = 8'h1C;
    step();
    inj_req = 1'b0;
    chk("inj10_k", 32'(kchar), 32'h01C);
    chk("inj10_ack", 32'(inj_ack), 1);
    chk("inj10_frame", 32'(frame_cnt), 11);
    step();
    chk("inj10_ack_off", 32'(inj_ack), 0);

    // Injection deferred past FC slot
    run_until_frame(254);
    inj_req = 1'b1;
    step();
    inj_req = 1'b0;
    chk("defer_fc", 32'(kchar), 32'h0FC);
    chk("defer_noack", 32'(inj_ack), 0);
    step();
    chk("defer_k", 32'(kchar), 32'h01C);
    chk("defer_frame", 32'(frame_cnt), 0);
    chk("defer_ack", 32'(inj_ack), 1);

    // Disable with an injection pending
    run_until_frame(254);
    inj_req = 1'b1; inj_kchar = 8'h3C;
    step();
    inj_req = 1'b0; fiber_enable = 1'b0;
    step();
    chk("dis_k", 32'(kchar), 0);
    chk("dis_ack", 32'(inj_ack), 0);
    chk("dis_tx", 32'(tx_active), 0);
    fiber_enable = 1'b1;
    for (int i = 0; i < HOLD + 5; i++) step();
    chk("dis_rerun", 32'(sync_done), 1);

    // Reset and resync together in RUN
    global_reset = 1'b1; ttc_resync = 1'b1;
    step();
    chk("rr_tx", 32'(tx_active), 0);
    chk("rr_k", 32'(kchar), 0);
    global_reset = 1'b0; ttc_resync = 1'b0;
    step();
    chk("rr_resync", 32'(tx_active), 1);

    // Randomized run
    for (int i = 0; i < 6000; i++) begin
      lvl = int'($urandom_range(0, 999));
      global_reset = (lvl == 0);
      fiber_enable = ($urandom_range(0, 999) != 0);
      ttc_resync   = ($urandom_range(0, 699) == 0);
      inj_req      = ($urandom_range(0, 15) == 0);
      inj_kchar    = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
